n_way_traffic_ctrl: RTL

Parametrised successor to the fixed four-approach signal controller. Sequences NUM_DIR approaches through GREEN -> YELLOW -> ALL-RED with independent per-phase durations. Supports a hold input and an optional demand-driven skip/extend mode. Sits at intersection top level and drives the per-approach lamp drivers directly.

---
 rtl/n_way_traffic_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/n_way_traffic_ctrl.sv
// N-approach signal controller: GREEN -> YELLOW -> ALL-RED per approach, with hold.
// Optional demand-driven skip/extend at green expiry when TRAFFIC_DEMAND_SKIP_EN is defined.

module n_way_traffic_lamp (
  input  logic       sel,
  input  logic [1:0] phase,
  output logic [1:0] lamp
);
  always_comb begin
    lamp = 2'b00;
    if (sel) begin
      case (phase)
        2'd0:    lamp = 2'b10;
        2'd1:    lamp = 2'b01;
        default: lamp = 2'b00;
      endcase
    end
  end
endmodule

module n_way_traffic_ctrl #(
  parameter  int NUM_DIR    = 4,
  parameter  int GREEN_CYC  = 8,
  parameter  int YELLOW_CYC = 4,
  parameter  int ALLRED_CYC = 2,
  localparam int DIR_W      = $clog2(NUM_DIR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIR_W-1:0]     start_dir,
  input  logic [NUM_DIR-1:0]   req,
  input  logic                 hold,
  output logic [2*NUM_DIR-1:0] lights,
  output logic [DIR_W-1:0]     active_dir,
  output logic [1:0]           phase
);
  localparam int MAX_DUR = (GREEN_CYC > YELLOW_CYC) ?
                           ((GREEN_CYC > ALLRED_CYC) ? GREEN_CYC : ALLRED_CYC) :
                           ((YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC);
  localparam int CNT_W = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(ALLRED_CYC - 1);
  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);
  localparam logic [DIR_W:0]   NDIR_EXT = (DIR_W+1)'(NUM_DIR);

  if (NUM_DIR < 2 || NUM_DIR > 8 || GREEN_CYC < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1) begin : g_param_err
    $error("n_way_traffic_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic [DIR_W-1:0] nxt_q, nxt_d;
  logic [DIR_W-1:0] start_sel;

  function automatic logic [DIR_W-1:0] inc_dir(input logic [DIR_W-1:0] d);
    return (d == LAST_DIR) ? '0 : d + DIR_W'(1);
  endfunction

  // Out-of-range start approach falls back to approach 0.
  assign start_sel = ({1'b0, start_dir} < NDIR_EXT) ? start_dir : '0;

`ifdef TRAFFIC_DEMAND_SKIP_EN
  logic             dmd_found;
  logic [DIR_W-1:0] dmd_pick;

  // Descending scan so the nearest requesting approach after dir_q wins.
  always_comb begin
    dmd_found = 1'b0;
    dmd_pick  = '0;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      int t;
      t = int'(dir_q) + k;
      if (t >= NUM_DIR) t = t - NUM_DIR;
      if (req[t]) begin
        dmd_found = 1'b1;
        dmd_pick  = DIR_W'(t);
      end
    end
  end
`else
  logic unused_req;
  assign unused_req = ^req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_GREEN;
      cnt_q   <= '0;
      dir_q   <= start_sel;
      nxt_q   <= inc_dir(start_sel);
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      nxt_q   <= nxt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    nxt_d   = nxt_q;
    case (phase_q)
      PH_GREEN: if (!hold) begin
        if (cnt_q == G_LAST) begin
          cnt_d = '0;
`ifdef TRAFFIC_DEMAND_SKIP_EN
          // No demand elsewhere: green is extended by restarting the count.
          if (dmd_found) begin
            phase_d = PH_YELLOW;
            nxt_d   = dmd_pick;
          end
`else
          phase_d = PH_YELLOW;
          nxt_d   = inc_dir(dir_q);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PH_YELLOW: if (!hold) begin
        if (cnt_q == Y_LAST) begin
          cnt_d   = '0;
          phase_d = PH_ALLRED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PH_ALLRED: if (!hold) begin
        if (cnt_q == R_LAST) begin
          cnt_d   = '0;
          phase_d = PH_GREEN;
          dir_d   = nxt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        phase_d = PH_GREEN;
        cnt_d   = '0;
        dir_d   = '0;
        nxt_d   = inc_dir('0);
      end
    endcase
  end

  logic [NUM_DIR-1:0][1:0] lamp;

  for (genvar i = 0; i < NUM_DIR; i++) begin : g_lane
    n_way_traffic_lamp u_lamp (
      .sel   (dir_q == DIR_W'(i)),
      .phase (phase_q),
      .lamp  (lamp[i])
    );
  end

  assign lights     = lamp;
  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule
